// File: rtl/scemi_inpipe_arbiter.sv
// scemi_inpipe_arbiter: shares one SCE-MI input pipe proxy between NUM_REQ
// transactor streams. Round-robin arbitration happens once per message, so a
// message's beats are never interleaved with another's. Each beat is tagged
// {last, source id, payload} and passes through a one-beat registered output
// stage. Optional stall watchdog: define SCEMI_ARB_WATCHDOG_EN.
module scemi_inpipe_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 32,
  parameter int ID_WIDTH = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_REQ-1:0]        REQ_VALID,
  input  logic [NUM_REQ-1:0]        REQ_LAST,
  input  logic [NUM_REQ*WIDTH-1:0]  REQ_DATA,
  output logic [NUM_REQ-1:0]        REQ_RDY,
  output logic [WIDTH+ID_WIDTH:0]   PIPE_DATA,
  output logic                      PIPE_EN,
  input  logic                      PIPE_RDY,
  output logic                      BUSY,
  output logic [ID_WIDTH-1:0]       GRANT_ID,
  output logic                      ERR
);

  localparam int OW = WIDTH + ID_WIDTH + 1;

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e                state_q;
  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic [ID_WIDTH-1:0]   grant_q;
  logic                  out_valid_q;
  logic [OW-1:0]         out_word_q;

  logic                  slot_free;
  logic                  g_valid;
  logic                  g_last;
  logic [WIDTH-1:0]      g_data;
  logic                  accept;
  logic                  timeout_hit;
  logic                  synth_fire;
  logic [ID_WIDTH-1:0]   rr_next;
  logic                  pick_valid;
  logic [ID_WIDTH-1:0]   pick_idx;

  // The output register can take a new beat when empty or draining this cycle.
  assign slot_free = !out_valid_q || PIPE_RDY;

  // Signals of the currently granted requester.
  assign g_valid = REQ_VALID[grant_q];
  assign g_last  = REQ_LAST[grant_q];
  assign g_data  = REQ_DATA[int'(grant_q)*WIDTH +: WIDTH];

  // The synthetic watchdog beat claims the slot instead of the requester.
  assign accept     = (state_q == S_GRANT) && g_valid && slot_free && !timeout_hit;
  assign synth_fire = timeout_hit && slot_free;

  // After a message, the just-served requester drops to lowest priority.
  assign rr_next = (int'(grant_q) + 1 == NUM_REQ) ? '0 : grant_q + 1'b1;

  assign PIPE_EN   = out_valid_q && PIPE_RDY;
  assign PIPE_DATA = out_word_q;
  assign BUSY      = (state_q == S_GRANT);
  assign GRANT_ID  = grant_q;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_valid && REQ_VALID[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx[ID_WIDTH-1:0];
      end
    end
  end

  // Ready goes only to the grantee, and only when its beat has somewhere to go.
  always_comb begin
    REQ_RDY = '0;
    if (state_q == S_GRANT && slot_free && !timeout_hit) begin
      REQ_RDY[grant_q] = 1'b1;
    end
  end

`ifdef SCEMI_ARB_WATCHDOG_EN
  localparam int SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_q;
  logic          err_q;

  assign timeout_hit = (state_q == S_GRANT) && (stall_q == SW'(TIMEOUT));
  assign ERR         = err_q;

  // Stall counter: counts granted cycles with no valid beat; error is sticky.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == S_IDLE) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (timeout_hit) begin
      if (slot_free) err_q <= 1'b1;
    end else if (!g_valid) begin
      stall_q <= stall_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign ERR         = 1'b0;
`endif

  // Arbitration FSM plus the one-beat output register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      // NOTE: the payload register is reset too because it drives PIPE_DATA
      // directly and must read as zero out of reset.
      out_word_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every update
      // samples the pre-edge values, independent of statement order.
      case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if ((accept && g_last) || synth_fire) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= rr_next;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (accept) begin
        out_word_q  <= {g_last, grant_q, g_data};
        out_valid_q <= 1'b1;
      end else if (synth_fire) begin
        out_word_q  <= {1'b1, grant_q, {WIDTH{1'b0}}};
        out_valid_q <= 1'b1;
      end else if (PIPE_RDY) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scemi_inpipe_arbiter.sv
// Directed bench for scemi_inpipe_arbiter (NUM_REQ=4, WIDTH=32, ID_WIDTH=2).
// Per-cycle vector tables for the basic flows, plus scripted sequences for
// backpressure, mid-message gaps, async reset and the optional watchdog.
module tb_scemi_inpipe_arbiter;

`ifdef SCEMI_ARB_WATCHDOG_EN
  localparam int TB_TIMEOUT = 8;
  localparam int DROP_LEN   = 6;
`else
  localparam int TB_TIMEOUT = 1024;
  localparam int DROP_LEN   = 10;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [3:0]    REQ_VALID = '0;
  logic [3:0]    REQ_LAST = '0;
  logic [127:0]  REQ_DATA = '0;
  logic [3:0]    REQ_RDY;
  logic [34:0]   PIPE_DATA;
  logic          PIPE_EN;
  logic          PIPE_RDY = 1'b1;
  logic          BUSY;
  logic [1:0]    GRANT_ID;
  logic          ERR;

  int n_checks = 0;
  int n_errors = 0;

  scemi_inpipe_arbiter #(
    .NUM_REQ(4), .WIDTH(32), .ID_WIDTH(2), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_LAST(REQ_LAST), .REQ_DATA(REQ_DATA),
    .REQ_RDY(REQ_RDY),
    .PIPE_DATA(PIPE_DATA), .PIPE_EN(PIPE_EN), .PIPE_RDY(PIPE_RDY),
    .BUSY(BUSY), .GRANT_ID(GRANT_ID), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]   valid;
    logic [3:0]   last;
    logic [127:0] data;
    logic         prdy;
    logic [3:0]   e_rdy;
    logic         e_en;
    logic [34:0]  e_data;
    logic         e_busy;
    logic [1:0]   e_gid;
  } vec_t;

  vec_t        vecs[$];
  logic [34:0] got_q[$];
  int          n_beats[4];
  int          base_v[4];
  int          drop_at[4];
  int          drop_len[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] dat(input logic [31:0] d3, input logic [31:0] d2,
                                       input logic [31:0] d1, input logic [31:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic [127:0] d,
                     input logic p, input logic [3:0] er, input logic ee,
                     input logic [34:0] ed, input logic eb, input logic [1:0] eg);
    vec_t t;
    t.valid = v; t.last = l; t.data = d; t.prdy = p;
    t.e_rdy = er; t.e_en = ee; t.e_data = ed; t.e_busy = eb; t.e_gid = eg;
    vecs.push_back(t);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQ_VALID = '0; REQ_LAST = '0; REQ_DATA = '0; PIPE_RDY = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Apply table rows lo..hi, one clock per row, checking outputs before the edge.
  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      REQ_VALID = vecs[i].valid;
      REQ_LAST  = vecs[i].last;
      REQ_DATA  = vecs[i].data;
      PIPE_RDY  = vecs[i].prdy;
      #1;
      check($sformatf("row%0d_rdy", i),  REQ_RDY,   vecs[i].e_rdy);
      check($sformatf("row%0d_en", i),   PIPE_EN,   vecs[i].e_en);
      check($sformatf("row%0d_data", i), PIPE_DATA, vecs[i].e_data);
      check($sformatf("row%0d_busy", i), BUSY,      vecs[i].e_busy);
      check($sformatf("row%0d_gid", i),  GRANT_ID,  vecs[i].e_gid);
      @(posedge CLK);
      #1;
    end
  endtask

  // Scripted requesters: n_beats from base_v, optional gap after drop_at beats,
  // optional PIPE_RDY stall after stall_after total accepted beats.
  task automatic run_seq(input int stall_after, input int stall_len);
    int sent[4];
    int drop_left[4];
    bit drop_done[4];
    int total, stall_left, tail, remaining;
    bit stall_done, done;
    logic [3:0]  acc;
    logic [34:0] acc_word, held;
    total = 0; stall_left = 0; tail = 0; stall_done = 0; done = 0; held = '0;
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0; drop_left[i] = 0; drop_done[i] = 0;
    end
    got_q.delete();
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        REQ_VALID[i] = (sent[i] < n_beats[i]) && (drop_left[i] == 0);
        REQ_LAST[i]  = REQ_VALID[i] && (sent[i] == n_beats[i] - 1);
        REQ_DATA[i*32 +: 32] = 32'(base_v[i] + sent[i]);
      end
      PIPE_RDY = (stall_left == 0);
      #1;
      if (PIPE_EN) got_q.push_back(PIPE_DATA);
      if (stall_left > 0) begin
        check("stall_rdy", REQ_RDY, 4'b0000);
        check("stall_hold", PIPE_DATA, held);
      end
      for (int i = 0; i < 4; i++) begin
        if (drop_left[i] > 0) begin
          check("gap_busy", BUSY, 1'b1);
          check("gap_gid", GRANT_ID, 2'(i));
        end
      end
      acc = REQ_VALID & REQ_RDY;
      acc_word = '0;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) acc_word = {REQ_LAST[i], 2'(i), REQ_DATA[i*32 +: 32]};
      end
      @(posedge CLK);
      #1;
      if (stall_left > 0) stall_left--;
      for (int i = 0; i < 4; i++) begin
        if (drop_left[i] > 0) drop_left[i]--;
        if (acc[i]) begin
          sent[i]++;
          total++;
          if (drop_at[i] == sent[i] && !drop_done[i]) begin
            drop_left[i] = drop_len[i];
            drop_done[i] = 1'b1;
          end
        end
      end
      if (!stall_done && stall_after > 0 && total == stall_after) begin
        stall_left = stall_len;
        stall_done = 1'b1;
        held = acc_word;
      end
      remaining = 0;
      for (int i = 0; i < 4; i++) remaining += n_beats[i] - sent[i];
      if (remaining == 0) begin
        tail++;
        if (tail > 3) done = 1'b1;
      end
    end
    check("seq_done", done, 1'b1);
    REQ_VALID = '0; REQ_LAST = '0; PIPE_RDY = 1'b1;
  endtask

  task automatic check_got(input string name, input logic [34:0] exp[$]);
    check({name, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", name, i), got_q[i], exp[i]);
  endtask

  initial begin
    logic [34:0] exp_q[$];

    // Rows 0..9: requester 2 three-beat message, then 2/3 contention from rr_ptr=3.
    add(4'b0100, 4'b0000, dat(0, 32'hA0, 0, 0), 1, 4'b0000, 0, 35'h0,           0, 2'd0);
    add(4'b0100, 4'b0000, dat(0, 32'hA0, 0, 0), 1, 4'b0100, 0, 35'h0,           1, 2'd2);
    add(4'b0100, 4'b0000, dat(0, 32'hA1, 0, 0), 1, 4'b0100, 1, 35'h2_000000A0,  1, 2'd2);
    add(4'b0100, 4'b0100, dat(0, 32'hA2, 0, 0), 1, 4'b0100, 1, 35'h2_000000A1,  1, 2'd2);
    add(4'b0000, 4'b0000, dat(0, 0, 0, 0),      1, 4'b0000, 1, 35'h6_000000A2,  0, 2'd2);
    add(4'b0000, 4'b0000, dat(0, 0, 0, 0),      1, 4'b0000, 0, 35'h6_000000A2,  0, 2'd2);
    add(4'b1100, 4'b1000, dat(32'hB3, 32'hC2, 0, 0), 1, 4'b0000, 0, 35'h6_000000A2, 0, 2'd2);
    add(4'b1100, 4'b1000, dat(32'hB3, 32'hC2, 0, 0), 1, 4'b1000, 0, 35'h6_000000A2, 1, 2'd3);
    add(4'b0000, 4'b0000, dat(0, 0, 0, 0),      1, 4'b0000, 1, 35'h7_000000B3,  0, 2'd3);
    add(4'b0000, 4'b0000, dat(0, 0, 0, 0),      1, 4'b0000, 0, 35'h7_000000B3,  0, 2'd3);
    // Rows 10..16: requesters 0,1,3 single-beat messages, simultaneous after reset.
    add(4'b1011, 4'b1011, dat(32'h13, 0, 32'h11, 32'h10), 1, 4'b0000, 0, 35'h0,          0, 2'd0);
    add(4'b1011, 4'b1011, dat(32'h13, 0, 32'h11, 32'h10), 1, 4'b0001, 0, 35'h0,          1, 2'd0);
    add(4'b1010, 4'b1010, dat(32'h13, 0, 32'h11, 32'h10), 1, 4'b0000, 1, 35'h4_00000010, 0, 2'd0);
    add(4'b1010, 4'b1010, dat(32'h13, 0, 32'h11, 32'h10), 1, 4'b0010, 0, 35'h4_00000010, 1, 2'd1);
    add(4'b1000, 4'b1000, dat(32'h13, 0, 32'h11, 32'h10), 1, 4'b0000, 1, 35'h5_00000011, 0, 2'd1);
    add(4'b1000, 4'b1000, dat(32'h13, 0, 32'h11, 32'h10), 1, 4'b1000, 0, 35'h5_00000011, 1, 2'd3);
    add(4'b0000, 4'b0000, dat(0, 0, 0, 0),                1, 4'b0000, 1, 35'h7_00000013, 0, 2'd3);

    do_reset();
    check("reset_err", ERR, 1'b0);
    run_table(0, 9);

    do_reset();
    run_table(10, 16);

    // Backpressure: requester 0 sends 4 beats, PIPE_RDY low 5 cycles after beat 1.
    do_reset();
    n_beats = '{4, 0, 0, 0}; base_v = '{32'h30, 0, 0, 0};
    drop_at = '{0, 0, 0, 0}; drop_len = '{0, 0, 0, 0};
    run_seq(1, 5);
    exp_q = '{35'h0_00000030, 35'h0_00000031, 35'h0_00000032, 35'h4_00000033};
    check_got("bp", exp_q);

    // Requester 1 pauses mid-message while requester 2 waits; no interleave.
    do_reset();
    n_beats = '{0, 3, 1, 0}; base_v = '{0, 32'h40, 32'h50, 0};
    drop_at = '{0, 1, 0, 0}; drop_len = '{0, DROP_LEN, 0, 0};
    run_seq(0, 0);
    exp_q = '{35'h1_00000040, 35'h1_00000041, 35'h5_00000042, 35'h6_00000050};
    check_got("gap", exp_q);

    // Async reset in GRANT with a beat in the output register (rr_ptr is 3 here).
    REQ_VALID = 4'b1000; REQ_LAST = 4'b0000; REQ_DATA = dat(32'h77, 0, 0, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("pre_rst_en", PIPE_EN, 1'b1);
    check("pre_rst_gid", GRANT_ID, 2'd3);
    #2;
    RST_N = 1'b0;
    #1;
    check("rst_en", PIPE_EN, 1'b0);
    check("rst_rdy", REQ_RDY, 4'b0000);
    check("rst_busy", BUSY, 1'b0);
    check("rst_data", PIPE_DATA, 35'h0);
    check("rst_gid", GRANT_ID, 2'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    REQ_VALID = 4'b1100; REQ_LAST = 4'b1100; REQ_DATA = dat(32'h88, 32'h99, 0, 0);
    @(posedge CLK); #1;
    check("post_rst_busy", BUSY, 1'b1);
    check("post_rst_gid", GRANT_ID, 2'd2);
    REQ_VALID = '0; REQ_LAST = '0;
    repeat (3) @(posedge CLK);
    #1;

`ifdef SCEMI_ARB_WATCHDOG_EN
    // Requester 3 stalls after one beat; watchdog closes its message.
    do_reset();
    REQ_VALID = 4'b1000; REQ_LAST = 4'b0000; REQ_DATA = dat(32'h90, 0, 0, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    REQ_VALID = 4'b0001; REQ_LAST = 4'b0001; REQ_DATA = dat(0, 0, 0, 32'hE0);
    begin
      int k;
      bit seen;
      seen = 1'b0;
      for (k = 0; k < 30 && !seen; k++) begin
        #1;
        if (PIPE_EN && PIPE_DATA == 35'h7_00000000) begin
          seen = 1'b1;
          check("wd_delay", k, 9);
          check("wd_err", ERR, 1'b1);
        end else begin
          @(posedge CLK); #1;
        end
      end
      check("wd_seen", seen, 1'b1);
    end
    @(posedge CLK); #1;
    check("wd_next_busy", BUSY, 1'b1);
    check("wd_next_gid", GRANT_ID, 2'd0);
    check("wd_err_sticky", ERR, 1'b1);
    REQ_VALID = '0; REQ_LAST = '0;
    repeat (3) @(posedge CLK);
`else
    check("final_err", ERR, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
